// File: rtl/decode_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage_pipe
// Description : RV32I decode stage with register file, D->E pipeline register,
//               execute stall/flush, load-use bubble insertion. Optional
//               writeback bypass enabled by the DECODE_BYPASS_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage_pipe #(
    parameter int D_WIDTH = 32,
    parameter int A_WIDTH = 5,
    parameter int NREG    = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ValidD,
    input  logic [D_WIDTH-1:0] InstrD,
    input  logic [D_WIDTH-1:0] PCD,
    input  logic [D_WIDTH-1:0] PCplus4D,
    input  logic               StallE,
    input  logic               FlushE,
    input  logic               WE3,
    input  logic [A_WIDTH-1:0] A3,
    input  logic [D_WIDTH-1:0] WD3,
    output logic               StallD,
    output logic               ValidE,
    output logic               RegWriteE,
    output logic               MemWriteE,
    output logic               JumpE,
    output logic               BranchE,
    output logic               ALUSrcE,
    output logic               JumpSrcE,
    output logic               ATypeE,
    output logic [1:0]         ResultSrcE,
    output logic [2:0]         ALUCtrlE,
    output logic [D_WIDTH-1:0] RD1E,
    output logic [D_WIDTH-1:0] RD2E,
    output logic [D_WIDTH-1:0] ImmExtE,
    output logic [D_WIDTH-1:0] PCE,
    output logic [D_WIDTH-1:0] PCplus4E,
    output logic [A_WIDTH-1:0] Rs1E,
    output logic [A_WIDTH-1:0] Rs2E,
    output logic [A_WIDTH-1:0] RdE,
    output logic [D_WIDTH-1:0] a0
);

    localparam logic [2:0] c_IMM_I = 3'd0;
    localparam logic [2:0] c_IMM_S = 3'd1;
    localparam logic [2:0] c_IMM_B = 3'd2;
    localparam logic [2:0] c_IMM_J = 3'd3;
    localparam logic [2:0] c_IMM_U = 3'd4;

    typedef struct packed {
        logic               valid;
        logic               regwrite;
        logic               memwrite;
        logic               jump;
        logic               branch;
        logic               alusrc;
        logic               jumpsrc;
        logic               atype;
        logic [1:0]         resultsrc;
        logic [2:0]         aluctrl;
        logic [D_WIDTH-1:0] rd1;
        logic [D_WIDTH-1:0] rd2;
        logic [D_WIDTH-1:0] imm;
        logic [D_WIDTH-1:0] pc;
        logic [D_WIDTH-1:0] pcplus4;
        logic [A_WIDTH-1:0] rs1;
        logic [A_WIDTH-1:0] rs2;
        logic [A_WIDTH-1:0] rd;
    } de_t;

    logic [6:0]         w_opcode;
    logic [2:0]         w_funct3;
    logic [A_WIDTH-1:0] w_rs1;
    logic [A_WIDTH-1:0] w_rs2;
    logic [A_WIDTH-1:0] w_rd;
    logic               w_regwrite, w_memwrite, w_jump, w_branch;
    logic               w_alusrc, w_jumpsrc, w_atype;
    logic [1:0]         w_resultsrc;
    logic [1:0]         w_aluop;
    logic [2:0]         w_immsrc;
    logic [2:0]         w_aluctrl;
    logic [31:0]        w_imm32;
    logic [D_WIDTH-1:0] w_rd1;
    logic [D_WIDTH-1:0] w_rd2;
    logic               w_wr_valid;
    logic               w_hazard;
    de_t                w_d;
    de_t                r_e;
    logic [D_WIDTH-1:0] r_rf [1:NREG-1];

    assign w_opcode = InstrD[6:0];
    assign w_funct3 = InstrD[14:12];
    assign w_rd     = InstrD[7  +: A_WIDTH];
    assign w_rs1    = InstrD[15 +: A_WIDTH];
    assign w_rs2    = InstrD[20 +: A_WIDTH];

    // Main control: lui/auipc share ResultSrc=11, ATypeE tells auipc apart
    always_comb begin
        w_regwrite  = 1'b0;
        w_memwrite  = 1'b0;
        w_jump      = 1'b0;
        w_branch    = 1'b0;
        w_alusrc    = 1'b0;
        w_jumpsrc   = 1'b0;
        w_atype     = 1'b0;
        w_resultsrc = 2'b00;
        w_aluop     = 2'b00;
        w_immsrc    = c_IMM_I;
        case (w_opcode)
            7'b0000011: begin w_regwrite = 1'b1; w_alusrc = 1'b1; w_resultsrc = 2'b01; end
            7'b0100011: begin w_memwrite = 1'b1; w_alusrc = 1'b1; w_immsrc = c_IMM_S; end
            7'b0110011: begin w_regwrite = 1'b1; w_aluop = 2'b10; end
            7'b1100011: begin w_branch = 1'b1; w_aluop = 2'b01; w_immsrc = c_IMM_B; end
            7'b0010011: begin w_regwrite = 1'b1; w_alusrc = 1'b1; w_aluop = 2'b10; end
            7'b1101111: begin
                w_regwrite = 1'b1; w_jump = 1'b1; w_resultsrc = 2'b10; w_immsrc = c_IMM_J;
            end
            7'b1100111: begin
                w_regwrite = 1'b1; w_jump = 1'b1; w_jumpsrc = 1'b1;
                w_alusrc = 1'b1; w_resultsrc = 2'b10;
            end
            7'b0110111: begin w_regwrite = 1'b1; w_resultsrc = 2'b11; w_immsrc = c_IMM_U; end
            7'b0010111: begin
                w_regwrite = 1'b1; w_resultsrc = 2'b11; w_atype = 1'b1; w_immsrc = c_IMM_U;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_aluctrl = 3'b000;
        case (w_aluop)
            2'b00: w_aluctrl = 3'b000;
            2'b01: w_aluctrl = 3'b001;
            default: begin
                case (w_funct3)
                    3'b000:  w_aluctrl = (w_opcode[5] & InstrD[30]) ? 3'b001 : 3'b000;
                    3'b001:  w_aluctrl = 3'b110;
                    3'b010:  w_aluctrl = 3'b101;
                    3'b011:  w_aluctrl = 3'b101;
                    3'b100:  w_aluctrl = 3'b100;
                    3'b101:  w_aluctrl = 3'b111;
                    3'b110:  w_aluctrl = 3'b011;
                    default: w_aluctrl = 3'b010;
                endcase
            end
        endcase
    end

    always_comb begin
        w_imm32 = '0;
        case (w_immsrc)
            c_IMM_I: w_imm32 = {{20{InstrD[31]}}, InstrD[31:20]};
            c_IMM_S: w_imm32 = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
            c_IMM_B: w_imm32 = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
            c_IMM_J: w_imm32 = {{12{InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
            c_IMM_U: w_imm32 = {InstrD[31:12], 12'b0};
            default: w_imm32 = '0;
        endcase
    end

    // Writes to x0 or to unimplemented registers never land anywhere
    assign w_wr_valid = WE3 && (A3 != '0) && (int'(A3) < NREG);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < NREG; i++) r_rf[i] <= '0;
        end else if (w_wr_valid) begin
            for (int i = 1; i < NREG; i++) begin
                if (A3 == A_WIDTH'(i)) r_rf[i] <= WD3;
            end
        end
    end

    always_comb begin
        w_rd1 = '0;
        w_rd2 = '0;
        for (int i = 1; i < NREG; i++) begin
            if (w_rs1 == A_WIDTH'(i)) w_rd1 = r_rf[i];
            if (w_rs2 == A_WIDTH'(i)) w_rd2 = r_rf[i];
        end
`ifdef DECODE_BYPASS_EN
        if (w_wr_valid && (A3 == w_rs1)) w_rd1 = WD3;
        if (w_wr_valid && (A3 == w_rs2)) w_rd2 = WD3;
`endif
    end

    generate
        if (NREG > 10) begin : g_a0
            assign a0 = r_rf[10];
        end else begin : g_no_a0
            assign a0 = '0;
        end
    endgenerate

    // Side-effecting controls are squashed when D carries no instruction
    always_comb begin
        w_d           = '0;
        w_d.valid     = ValidD;
        w_d.regwrite  = w_regwrite & ValidD;
        w_d.memwrite  = w_memwrite & ValidD;
        w_d.jump      = w_jump & ValidD;
        w_d.branch    = w_branch & ValidD;
        w_d.alusrc    = w_alusrc;
        w_d.jumpsrc   = w_jumpsrc;
        w_d.atype     = w_atype;
        w_d.resultsrc = w_resultsrc;
        w_d.aluctrl   = w_aluctrl;
        w_d.rd1       = w_rd1;
        w_d.rd2       = w_rd2;
        w_d.imm       = D_WIDTH'($signed(w_imm32));
        w_d.pc        = PCD;
        w_d.pcplus4   = PCplus4D;
        w_d.rs1       = w_rs1;
        w_d.rs2       = w_rs2;
        w_d.rd        = w_rd;
    end

    assign w_hazard = r_e.valid && (r_e.resultsrc == 2'b01) && (r_e.rd != '0) && ValidD &&
                      ((r_e.rd == w_rs1) || (r_e.rd == w_rs2));

    // A flushed hazard needs no hold: the consumer leaves D along with the flush
    assign StallD = StallE | (w_hazard & ~FlushE);

    always_ff @(posedge clk) begin
        if (rst || FlushE) begin
            r_e <= '0;
        end else if (StallE) begin
            r_e <= r_e;
        end else if (w_hazard) begin
            r_e <= '0;
        end else begin
            r_e <= w_d;
        end
    end

    assign ValidE     = r_e.valid;
    assign RegWriteE  = r_e.regwrite;
    assign MemWriteE  = r_e.memwrite;
    assign JumpE      = r_e.jump;
    assign BranchE    = r_e.branch;
    assign ALUSrcE    = r_e.alusrc;
    assign JumpSrcE   = r_e.jumpsrc;
    assign ATypeE     = r_e.atype;
    assign ResultSrcE = r_e.resultsrc;
    assign ALUCtrlE   = r_e.aluctrl;
    assign RD1E       = r_e.rd1;
    assign RD2E       = r_e.rd2;
    assign ImmExtE    = r_e.imm;
    assign PCE        = r_e.pc;
    assign PCplus4E   = r_e.pcplus4;
    assign Rs1E       = r_e.rs1;
    assign Rs2E       = r_e.rs2;
    assign RdE        = r_e.rd;

endmodule
`default_nettype wire
